// File: rtl/coin_pulse_conditioner_if.sv
// Coin sensor / coin pulse bundle between the sensor front end and the vending FSM.
// master drives the sensor levels and controls, slave is the conditioner.
interface coin_pulse_conditioner_if;
    logic       ena;
    logic       raw_x;
    logic       raw_y;
    logic       tot_clr;
    logic       coin_x;
    logic       coin_y;
    logic [7:0] coin_total;
    logic       pend_ovf;

    modport master (
        output ena, raw_x, raw_y, tot_clr,
        input  coin_x, coin_y, coin_total, pend_ovf
    );

    modport slave (
        input  ena, raw_x, raw_y, tot_clr,
        output coin_x, coin_y, coin_total, pend_ovf
    );
endinterface

// File: rtl/coin_pulse_conditioner.sv
// Raw coin sensor levels -> synchronise, debounce, edge-detect, pend, arbitrate
// into single-cycle coin pulses; also keeps a saturating rupee total.
module coin_pulse_conditioner #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned DB_W      = 5,
    parameter int unsigned GAP       = 1
) (
    input logic                     clk,
    input logic                     rst_n,
    coin_pulse_conditioner_if.slave cp
);
    localparam int unsigned       GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP);

    typedef enum logic {
        ARB_IDLE,
        ARB_GAP
    } arb_state_e;

    // Channel index 0 is the 1-rupee (x) sensor, index 1 the 2-rupee (y) sensor.
    logic [1:0]            raw;
    logic [1:0]            s1_q, s1_d;
    logic [1:0]            s2_q, s2_d;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            rise;
    logic                  pend_ovf_q, pend_ovf_d;
    logic [7:0]            total_q, total_d;
    logic [8:0]            total_sum;
    logic                  emit_x, emit_y;

    arb_state_e            state_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic                  coin_x_q, coin_y_q;

    assign raw    = {cp.raw_y, cp.raw_x};
    assign emit_x = cp.ena && (state_q == ARB_IDLE) && pend_q[0];
    assign emit_y = cp.ena && (state_q == ARB_IDLE) && !pend_q[0] && pend_q[1];

    always_comb begin
        s1_d       = s1_q;
        s2_d       = s2_q;
        stable_d   = stable_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_ovf_d = pend_ovf_q;
        rise       = '0;
        if (cp.ena) begin
            s1_d = raw;
            s2_d = s1_q;
            for (int unsigned i = 0; i < 2; i++) begin
                if (s2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == DB_LAST) begin
                        stable_d[i] = s2_q[i];
                        cnt_d[i]    = '0;
                        rise[i]     = s2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
            // Emission releases the flag before the new event is merged in, so a coin
            // accepted on the emitting edge is kept rather than counted as an overflow.
            if (emit_x) pend_d[0] = 1'b0;
            if (emit_y) pend_d[1] = 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                if (rise[i]) begin
                    if (pend_d[i]) pend_ovf_d = 1'b1;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        total_sum = {1'b0, total_q} + (emit_y ? 9'd2 : (emit_x ? 9'd1 : 9'd0));
        total_d   = total_q;
        if (cp.ena) begin
            if (cp.tot_clr) begin
                total_d = emit_y ? 8'd2 : (emit_x ? 8'd1 : 8'd0);
            end else if (total_sum[8]) begin
                total_d = '1;
            end else begin
                total_d = total_sum[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_ovf_q <= 1'b0;
            total_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_ovf_q <= pend_ovf_d;
            total_q    <= total_d;
        end
    end

    // Arbiter: emits at most one coin per cycle, x before y, then idles for GAP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gap_cnt_q <= '0;
            coin_x_q  <= 1'b0;
            coin_y_q  <= 1'b0;
        end else if (!cp.ena) begin
            coin_x_q <= 1'b0;
            coin_y_q <= 1'b0;
        end else begin
            coin_x_q <= emit_x;
            coin_y_q <= emit_y;
            if (state_q == ARB_IDLE) begin
                if ((emit_x || emit_y) && (GAP > 0)) begin
                    state_q   <= ARB_GAP;
                    gap_cnt_q <= GAP_LOAD;
                end
            end else begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_q <= ARB_IDLE;
                end else begin
                    gap_cnt_q <= gap_cnt_q - 1'b1;
                end
            end
        end
    end

    assign cp.coin_x     = coin_x_q;
    assign cp.coin_y     = coin_y_q;
    assign cp.coin_total = total_q;
    assign cp.pend_ovf   = pend_ovf_q;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Self-checking bench: directed latency/arbitration/saturation/reset cases plus
// randomized sensor traffic, all compared against a behavioural model.
module tb_coin_pulse_conditioner;
    localparam int DBC  = 4;
    localparam int GAPC = 1;

    logic clk = 1'b0;
    logic rst_n;

    coin_pulse_conditioner_if cp ();

    coin_pulse_conditioner #(
        .DB_CYCLES (DBC),
        .DB_W      (3),
        .GAP       (GAPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cp    (cp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: delay line of two samples, run-length acceptance, pending
    // coins, cooldown counter between emissions, clamped running total.
    int m_dly1[2], m_dly2[2], m_level[2], m_run[2];
    bit m_pend[2];
    bit m_ovf, m_x, m_y;
    int m_total, m_cool;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_dly1[c] = 0; m_dly2[c] = 0; m_level[c] = 0; m_run[c] = 0; m_pend[c] = 0;
        end
        m_ovf = 0; m_x = 0; m_y = 0; m_total = 0; m_cool = 0;
    endtask

    task automatic model_edge(input bit rx, input bit ry, input bit en, input bit clr);
        int r[2];
        int seen;
        bit acc[2];
        bit ex, ey;
        int v;
        r[0] = int'(rx); r[1] = int'(ry);
        ex = 0; ey = 0;
        if (!en) begin
            m_x = 0; m_y = 0;
            return;
        end
        if (m_cool > 0) m_cool--;
        else if (m_pend[0]) ex = 1;
        else if (m_pend[1]) ey = 1;
        if (ex || ey) m_cool = GAPC;
        for (int c = 0; c < 2; c++) begin
            seen = m_dly2[c];
            m_dly2[c] = m_dly1[c];
            m_dly1[c] = r[c];
            acc[c] = 0;
            if (seen != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == DBC) begin
                    m_level[c] = seen;
                    m_run[c] = 0;
                    acc[c] = (seen == 1);
                end
            end else begin
                m_run[c] = 0;
            end
        end
        if (ex) m_pend[0] = 0;
        if (ey) m_pend[1] = 0;
        for (int c = 0; c < 2; c++) begin
            if (acc[c]) begin
                if (m_pend[c]) m_ovf = 1;
                m_pend[c] = 1;
            end
        end
        v = ex ? 1 : (ey ? 2 : 0);
        if (clr) m_total = v;
        else m_total = (m_total + v > 255) ? 255 : m_total + v;
        m_x = ex; m_y = ey;
    endtask

    // Called at a negedge; drives inputs, models the next posedge, checks, returns at the next negedge.
    task automatic cycle(input bit rx, input bit ry, input bit en, input bit clr);
        cp.raw_x = rx; cp.raw_y = ry; cp.ena = en; cp.tot_clr = clr;
        @(posedge clk);
        model_edge(rx, ry, en, clr);
        #1;
        chk("coin_x", cp.coin_x, m_x);
        chk("coin_y", cp.coin_y, m_y);
        chk("coin_total", cp.coin_total, m_total);
        chk("pend_ovf", cp.pend_ovf, m_ovf);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cp.raw_x = 0; cp.raw_y = 0; cp.ena = 1; cp.tot_clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int hold[2];
        bit lvl[2];
        bit en, clr;

        do_reset();
        #1;
        chk("reset_coin_x", cp.coin_x, 0);
        chk("reset_total", cp.coin_total, 0);
        chk("reset_ovf", cp.pend_ovf, 0);

        // T1: single coin, pulse after edge DB_CYCLES+3
        for (int k = 1; k <= 10; k++) begin
            cycle(1, 0, 1, 0);
            chk("t1_pulse", cp.coin_x, (k == 7));
        end
        chk("t1_total", cp.coin_total, 1);

        // T2: bouncing raw_y never accepted
        do_reset();
        for (int k = 0; k < 30; k++) begin
            cycle(0, (k < 20) ? bit'(k % 2) : 1'b0, 1, 0);
            chk("t2_no_coin", cp.coin_y, 0);
        end
        chk("t2_total", cp.coin_total, 0);

        // T3: simultaneous coins serialised, x first, y GAP+1 later
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle(k <= 10, k <= 10, 1, 0);
            chk("t3_x", cp.coin_x, (k == 7));
            chk("t3_y", cp.coin_y, (k == 9));
        end
        chk("t3_total", cp.coin_total, 3);

        // T4: ena low while pending defers the pulse
        do_reset();
        for (int k = 1; k <= 6; k++) cycle(1, 0, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0, 0, 0);
            chk("t4_frozen", cp.coin_x, 0);
        end
        cycle(1, 0, 1, 0);
        chk("t4_deferred", cp.coin_x, 1);
        cycle(1, 0, 1, 0);
        chk("t4_single", cp.coin_x, 0);
        chk("t4_total", cp.coin_total, 1);

        // T5: 130 two-rupee coins saturate the total, then clear
        do_reset();
        for (int n = 0; n < 130; n++) begin
            for (int k = 0; k < 8; k++) cycle(0, 1, 1, 0);
            for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0);
        end
        chk("t5_saturate", cp.coin_total, 255);
        cycle(0, 0, 1, 1);
        chk("t5_clear", cp.coin_total, 0);

        // T6: async reset mid-debounce, then latency restarts from scratch
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1, 0, 1, 0);
        for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_x", cp.coin_x, 0);
        chk("t6_rst_y", cp.coin_y, 0);
        chk("t6_rst_total", cp.coin_total, 0);
        chk("t6_rst_ovf", cp.pend_ovf, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cycle(1, 0, 1, 0);
            chk("t6_relatency", cp.coin_x, (k == 7));
        end

        // Randomized sensor traffic with bounce, ena gaps, clears and aligned coins
        do_reset();
        hold[0] = 0; hold[1] = 0; lvl[0] = 0; lvl[1] = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                lvl[0] = 1; lvl[1] = 1; hold[0] = 10; hold[1] = 10;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (hold[c] == 0) begin
                        lvl[c]  = ~lvl[c];
                        hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                                              : int'($urandom_range(4, 14));
                    end else begin
                        hold[c]--;
                    end
                end
            end
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 63) == 0);
            cycle(lvl[0], lvl[1], en, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
